// File: rtl/apb_slave_regfile.sv
// APB3 completer register bank: NUM_REGS-1 R/W words plus a read-only status word at the top index,
// programmable wait states and decode errors. Define APB_SLV_PSTRB_EN to add APB4 byte strobes (i_pstrb).
module apb_slave_regfile #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = {ADDR_WIDTH{1'b0}},
    parameter int                    WAIT_STATES = 1
) (
    input  logic                               i_clk_apb,
    input  logic                               i_rst_apb,
    input  logic                               i_psel,
    input  logic                               i_penable,
    input  logic                               i_pwrite,
    input  logic [ADDR_WIDTH-1:0]              i_paddr,
    input  logic [DATA_WIDTH-1:0]              i_pwdata,
    output logic [DATA_WIDTH-1:0]              o_prdata,
    output logic                               o_pready,
    output logic                               o_pslverr,
    input  logic [DATA_WIDTH-1:0]              i_status,
`ifdef APB_SLV_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0]            i_pstrb,
`endif
    output logic [(NUM_REGS-1)*DATA_WIDTH-1:0] o_regs
);

    localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] STATUS_IDX = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [3:0]            WAIT_INIT  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS-1];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS-1];

    logic                  setup_s;
    logic                  load_s;
    logic                  commit_s;
    logic [ADDR_WIDTH-1:0] dec_addr_s;
    logic                  dec_write_s;
    logic [ADDR_WIDTH-1:0] off_s;
    logic [ADDR_WIDTH-1:0] idx_s;
    logic                  strb_err_s;
    logic                  dec_err_s;
    logic [DATA_WIDTH-1:0] wmask_s;
    logic [DATA_WIDTH-1:0] reg_mux_s;
    logic [DATA_WIDTH-1:0] rd_data_s;

    assign setup_s = (state_q == ST_IDLE) && i_psel && !i_penable;

`ifdef APB_SLV_PSTRB_EN
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [STRB_W-1:0] strb_q, strb_d;
    logic [STRB_W-1:0] dec_strb_s;

    // Strobe capture, per-byte write mask and read-with-strobe error
    always_comb begin
        strb_d     = setup_s ? i_pstrb : strb_q;
        dec_strb_s = (state_q == ST_IDLE) ? i_pstrb : strb_q;
        strb_err_s = !dec_write_s && (dec_strb_s != {STRB_W{1'b0}});
        for (int b = 0; b < STRB_W; b++) begin
            wmask_s[b*8 +: 8] = {8{strb_q[b]}};
        end
    end

    always_ff @(posedge i_clk_apb) begin
        if (i_rst_apb) begin
            strb_q <= {STRB_W{1'b0}};
        end else begin
            strb_q <= strb_d;
        end
    end
`else
    assign strb_err_s = 1'b0;
    assign wmask_s    = {DATA_WIDTH{1'b1}};
`endif

    // Decode the live bus in IDLE (zero-wait case) and the captured transfer afterwards
    always_comb begin
        dec_addr_s  = (state_q == ST_IDLE) ? i_paddr : addr_q;
        dec_write_s = (state_q == ST_IDLE) ? i_pwrite : write_q;
        off_s       = dec_addr_s - BASE_ADDR;
        idx_s       = {2'b00, off_s[ADDR_WIDTH-1:2]};
        dec_err_s   = (off_s[1:0] != 2'b00)
                   || (dec_addr_s < BASE_ADDR)
                   || (idx_s >= NUM_REGS_A)
                   || (dec_write_s && (idx_s == STATUS_IDX))
                   || strb_err_s;
    end

    // Read data selection
    always_comb begin
        reg_mux_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            reg_mux_s = reg_mux_s | (regs_q[i] & {DATA_WIDTH{idx_s == ADDR_WIDTH'(i)}});
        end
        rd_data_s = (idx_s == STATUS_IDX) ? i_status : reg_mux_s;
    end

    // Transfer FSM and registered response
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        load_s    = 1'b0;
        commit_s  = 1'b0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = {DATA_WIDTH{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (setup_s) begin
                    addr_d  = i_paddr;
                    write_d = i_pwrite;
                    wdata_d = i_pwdata;
                    cnt_d   = WAIT_INIT;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                        load_s  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!i_psel) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (i_penable && (cnt_q == 4'd1)) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                    load_s  = 1'b1;
                end else if (i_penable) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_RESP: begin
                state_d  = ST_IDLE;
                commit_s = i_psel && write_q && !dec_err_s;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (load_s) begin
            pready_d  = 1'b1;
            pslverr_d = dec_err_s;
            prdata_d  = (dec_err_s || dec_write_s) ? {DATA_WIDTH{1'b0}} : rd_data_s;
        end else begin
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = {DATA_WIDTH{1'b0}};
        end
    end

    // Register write-back (byte-masked when strobes are enabled)
    always_comb begin
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            if (commit_s && (idx_s == ADDR_WIDTH'(i))) begin
                regs_d[i] = (regs_q[i] & ~wmask_s) | (wdata_q & wmask_s);
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            o_regs[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge i_clk_apb) begin
        if (i_rst_apb) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= {ADDR_WIDTH{1'b0}};
            write_q   <= 1'b0;
            wdata_q   <= {DATA_WIDTH{1'b0}};
            prdata_q  <= {DATA_WIDTH{1'b0}};
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                regs_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign o_prdata  = prdata_q;
    assign o_pready  = pready_q;
    assign o_pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: instance A (16 regs, base 0, 2 wait states) and
// instance B (4 regs, base 0x100, zero wait states) share the bus but have separate selects.
module tb_apb_slave_regfile;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, psel_a, psel_b, penable, pwrite;
    logic [31:0] paddr, pwdata, status;
    logic [31:0] prdata_a, prdata_b;
    logic        pready_a, pready_b, pslverr_a, pslverr_b;
    logic [479:0] regs_a;
    logic [95:0]  regs_b;
`ifdef APB_SLV_PSTRB_EN
    logic [3:0]  pstrb, strb_val;
    logic        use_strb;
`endif

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] rd;
    logic        er, ok;
    int          cy;
    logic [479:0] exp_a;

    apb_slave_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(16),
                        .BASE_ADDR(32'h0), .WAIT_STATES(2)) u_dut_a (
        .i_clk_apb(clk), .i_rst_apb(rst), .i_psel(psel_a), .i_penable(penable),
        .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata), .o_prdata(prdata_a),
        .o_pready(pready_a), .o_pslverr(pslverr_a), .i_status(status),
`ifdef APB_SLV_PSTRB_EN
        .i_pstrb(pstrb),
`endif
        .o_regs(regs_a));

    apb_slave_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(4),
                        .BASE_ADDR(32'h100), .WAIT_STATES(0)) u_dut_b (
        .i_clk_apb(clk), .i_rst_apb(rst), .i_psel(psel_b), .i_penable(penable),
        .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata), .o_prdata(prdata_b),
        .o_pready(pready_b), .o_pslverr(pslverr_b), .i_status(status),
`ifdef APB_SLV_PSTRB_EN
        .i_pstrb(pstrb),
`endif
        .o_regs(regs_b));

    // One complete APB transfer; starts and ends 1 time unit after a rising edge.
    task automatic apb_xfer(input logic which_b, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output logic err, output int cycles, output logic idle_ok);
        paddr = addr; pwdata = wdata; pwrite = wr; penable = 1'b0;
`ifdef APB_SLV_PSTRB_EN
        pstrb = use_strb ? strb_val : (wr ? 4'hF : 4'h0);
`endif
        psel_a = !which_b; psel_b = which_b;
        @(posedge clk); #1;
        penable = 1'b1;
        cycles = -1; rdata = 32'h0; err = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if ((which_b ? pready_b : pready_a) === 1'b1) begin
                cycles = n;
                rdata  = which_b ? prdata_b : prdata_a;
                err    = which_b ? pslverr_b : pslverr_a;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
        idle_ok = which_b ? (pready_b === 1'b0 && pslverr_b === 1'b0 && prdata_b === 32'h0)
                          : (pready_a === 1'b0 && pslverr_a === 1'b0 && prdata_a === 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0; status = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (regs_a !== 480'h0) begin n_fail++; $display("FAIL reset_regs_a: got %h want 0", regs_a); end
        n_cmp++; if (regs_b !== 96'h0) begin n_fail++; $display("FAIL reset_regs_b: got %h want 0", regs_b); end
        n_cmp++; if ({pready_a, pslverr_a} !== 2'b00) begin n_fail++; $display("FAIL reset_rdy_err: got %b want 00", {pready_a, pslverr_a}); end
        n_cmp++; if (prdata_a !== 32'h0) begin n_fail++; $display("FAIL reset_prdata: got %h want 0", prdata_a); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_wait_rw();
        apb_xfer(1'b0, 1'b1, 32'h0C, 32'hDEADBEEF, rd, er, cy, ok);
        n_cmp++; if (cy !== 3 || er !== 1'b0) begin n_fail++; $display("FAIL wr_0c: cycles %0d err %b want 3 0", cy, er); end
        n_cmp++; if (regs_a[127:96] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_0c_reg3: got %h want deadbeef", regs_a[127:96]); end
        apb_xfer(1'b0, 1'b0, 32'h0C, 32'h0, rd, er, cy, ok);
        n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_fail++; $display("FAIL rd_0c: got %h err %b want deadbeef 0", rd, er); end
        n_cmp++; if (cy !== 3) begin n_fail++; $display("FAIL rd_0c_latency: got %0d want 3", cy); end
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rd_0c_drop: prdata/pready not cleared, got %b want 1", ok); end
    endtask

    task automatic test_decode_err();
        apb_xfer(1'b0, 1'b0, 32'h40, 32'h0, rd, er, cy, ok);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0 || cy !== 3) begin n_fail++; $display("FAIL rd_40_range: err %b data %h cyc %0d want 1 0 3", er, rd, cy); end
    endtask

    task automatic test_status();
        status = 32'h1234;
        exp_a = 480'h0; exp_a[127:96] = 32'hDEADBEEF;
        apb_xfer(1'b0, 1'b0, 32'h3C, 32'h0, rd, er, cy, ok);
        n_cmp++; if (rd !== 32'h1234 || er !== 1'b0) begin n_fail++; $display("FAIL rd_status: got %h err %b want 1234 0", rd, er); end
        apb_xfer(1'b0, 1'b1, 32'h3C, 32'hFFFFFFFF, rd, er, cy, ok);
        n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL wr_status_err: got %b want 1", er); end
        n_cmp++; if (regs_a !== exp_a) begin n_fail++; $display("FAIL wr_status_regs: got %h want %h", regs_a, exp_a); end
        apb_xfer(1'b0, 1'b0, 32'h3C, 32'h0, rd, er, cy, ok);
        n_cmp++; if (rd !== 32'h1234) begin n_fail++; $display("FAIL rd_status_again: got %h want 1234", rd); end
    endtask

    task automatic test_misaligned();
        apb_xfer(1'b0, 1'b1, 32'h04, 32'h5555AAAA, rd, er, cy, ok);
        n_cmp++; if (regs_a[63:32] !== 32'h5555AAAA || er !== 1'b0) begin n_fail++; $display("FAIL wr_04: got %h err %b want 5555aaaa 0", regs_a[63:32], er); end
        apb_xfer(1'b0, 1'b1, 32'h06, 32'h12345678, rd, er, cy, ok);
        n_cmp++; if (er !== 1'b1 || regs_a[63:32] !== 32'h5555AAAA) begin n_fail++; $display("FAIL wr_06_misalign: err %b reg1 %h want 1 5555aaaa", er, regs_a[63:32]); end
        apb_xfer(1'b0, 1'b0, 32'h06, 32'h0, rd, er, cy, ok);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL rd_06_misalign: err %b data %h want 1 0", er, rd); end
    endtask

    task automatic test_abort();
        // drop psel while still waiting
        paddr = 32'h04; pwdata = 32'h99999999; pwrite = 1'b1; penable = 1'b0; psel_a = 1'b1;
`ifdef APB_SLV_PSTRB_EN
        pstrb = 4'hF;
`endif
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk); #1; psel_a = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (pready_a !== 1'b0) begin n_fail++; $display("FAIL abort_wait_rdy: got %b want 0", pready_a); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (regs_a[63:32] !== 32'h5555AAAA) begin n_fail++; $display("FAIL abort_wait_reg1: got %h want 5555aaaa", regs_a[63:32]); end
        // drop psel during the response cycle
        psel_a = 1'b1; penable = 1'b0;
        @(posedge clk); #1; penable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (pready_a !== 1'b1) begin n_fail++; $display("FAIL abort_resp_rdy: got %b want 1", pready_a); end
        psel_a = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if ({pready_a, pslverr_a} !== 2'b00 || regs_a[63:32] !== 32'h5555AAAA) begin n_fail++; $display("FAIL abort_resp: rdy/err %b reg1 %h want 00 5555aaaa", {pready_a, pslverr_a}, regs_a[63:32]); end
    endtask

    task automatic test_penable_no_setup();
        logic seen;
        seen = 1'b0;
        paddr = 32'h04; pwdata = 32'h77777777; pwrite = 1'b1; psel_a = 1'b1; penable = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            seen = seen | pready_a;
        end
        psel_a = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (seen !== 1'b0 || regs_a[63:32] !== 32'h5555AAAA) begin n_fail++; $display("FAIL penable_only: rdy seen %b reg1 %h want 0 5555aaaa", seen, regs_a[63:32]); end
    endtask

    task automatic test_back_to_back();
        apb_xfer(1'b0, 1'b1, 32'h10, 32'h01020304, rd, er, cy, ok);
        n_cmp++; if (cy !== 3 || ok !== 1'b1) begin n_fail++; $display("FAIL b2b_wr4: cyc %0d idle %b want 3 1", cy, ok); end
        apb_xfer(1'b0, 1'b1, 32'h14, 32'hA5A5A5A5, rd, er, cy, ok);
        n_cmp++; if (cy !== 3 || regs_a[191:160] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL b2b_wr5: cyc %0d reg5 %h want 3 a5a5a5a5", cy, regs_a[191:160]); end
        apb_xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, er, cy, ok);
        n_cmp++; if (rd !== 32'h01020304 || cy !== 3) begin n_fail++; $display("FAIL b2b_rd4: got %h cyc %0d want 01020304 3", rd, cy); end
        apb_xfer(1'b0, 1'b0, 32'h14, 32'h0, rd, er, cy, ok);
        n_cmp++; if (rd !== 32'hA5A5A5A5 || ok !== 1'b1) begin n_fail++; $display("FAIL b2b_rd5: got %h idle %b want a5a5a5a5 1", rd, ok); end
    endtask

`ifdef APB_SLV_PSTRB_EN
    task automatic test_pstrb();
        use_strb = 1'b1;
        strb_val = 4'hF;
        apb_xfer(1'b0, 1'b1, 32'h08, 32'h11223344, rd, er, cy, ok);
        strb_val = 4'b0101;
        apb_xfer(1'b0, 1'b1, 32'h08, 32'hAABBCCDD, rd, er, cy, ok);
        n_cmp++; if (regs_a[95:64] !== 32'h11BB33DD) begin n_fail++; $display("FAIL pstrb_merge: got %h want 11bb33dd", regs_a[95:64]); end
        strb_val = 4'b0001;
        apb_xfer(1'b0, 1'b0, 32'h08, 32'h0, rd, er, cy, ok);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL pstrb_read_err: err %b data %h want 1 0", er, rd); end
        strb_val = 4'b0000;
        apb_xfer(1'b0, 1'b0, 32'h08, 32'h0, rd, er, cy, ok);
        n_cmp++; if (er !== 1'b0 || rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL pstrb_read_ok: err %b data %h want 0 11bb33dd", er, rd); end
        use_strb = 1'b0;
    endtask
`endif

    task automatic test_zero_wait_base();
        apb_xfer(1'b1, 1'b1, 32'h104, 32'hCAFEF00D, rd, er, cy, ok);
        n_cmp++; if (cy !== 1 || er !== 1'b0 || regs_b[63:32] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b_wr_104: cyc %0d err %b reg1 %h want 1 0 cafef00d", cy, er, regs_b[63:32]); end
        apb_xfer(1'b1, 1'b0, 32'h104, 32'h0, rd, er, cy, ok);
        n_cmp++; if (rd !== 32'hCAFEF00D || cy !== 1 || ok !== 1'b1) begin n_fail++; $display("FAIL b_rd_104: got %h cyc %0d idle %b want cafef00d 1 1", rd, cy, ok); end
        apb_xfer(1'b1, 1'b0, 32'hFC, 32'h0, rd, er, cy, ok);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL b_below_base: err %b data %h want 1 0", er, rd); end
        apb_xfer(1'b1, 1'b0, 32'h10C, 32'h0, rd, er, cy, ok);
        n_cmp++; if (er !== 1'b0 || rd !== 32'h1234) begin n_fail++; $display("FAIL b_status: err %b data %h want 0 1234", er, rd); end
        apb_xfer(1'b1, 1'b1, 32'h10C, 32'h5A5A5A5A, rd, er, cy, ok);
        n_cmp++; if (er !== 1'b1 || regs_b !== {64'h0, 32'hCAFEF00D, 32'h0}) begin n_fail++; $display("FAIL b_wr_status: err %b regs %h", er, regs_b); end
        apb_xfer(1'b1, 1'b0, 32'h110, 32'h0, rd, er, cy, ok);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL b_above_map: err %b data %h want 1 0", er, rd); end
    endtask

    task automatic test_reset_mid();
        paddr = 32'h00; pwdata = 32'hFFFF0000; pwrite = 1'b1; penable = 1'b0; psel_a = 1'b1;
`ifdef APB_SLV_PSTRB_EN
        pstrb = 4'hF;
`endif
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (regs_a !== 480'h0 || regs_b !== 96'h0) begin n_fail++; $display("FAIL reset_mid_regs: a %h b %h want 0", regs_a, regs_b); end
        n_cmp++; if ({pready_a, pslverr_a} !== 2'b00) begin n_fail++; $display("FAIL reset_mid_rdy: got %b want 00", {pready_a, pslverr_a}); end
        rst = 1'b0;
        @(posedge clk); #1;
        psel_a = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (regs_a[31:0] !== 32'h0) begin n_fail++; $display("FAIL reset_mid_nowrite: got %h want 0", regs_a[31:0]); end
        apb_xfer(1'b0, 1'b0, 32'h0C, 32'h0, rd, er, cy, ok);
        n_cmp++; if (rd !== 32'h0 || er !== 1'b0 || cy !== 3) begin n_fail++; $display("FAIL reset_mid_recover: data %h err %b cyc %0d want 0 0 3", rd, er, cy); end
    endtask

    initial begin
`ifdef APB_SLV_PSTRB_EN
        use_strb = 1'b0; strb_val = 4'h0; pstrb = 4'h0;
`endif
        test_reset();
        test_wait_rw();
        test_decode_err();
        test_status();
        test_misaligned();
        test_abort();
        test_penable_no_setup();
        test_back_to_back();
`ifdef APB_SLV_PSTRB_EN
        test_pstrb();
`endif
        test_zero_wait_base();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
